// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM (1-cycle latency) between
// NUM_REQ requesters, with a valid/ready request side and a held, one-hot response side.
module rom_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data
);

    localparam int GNT_WIDTH = $clog2(NUM_REQ);
    localparam logic [GNT_WIDTH:0]   NUM_REQ_W = (GNT_WIDTH+1)'(NUM_REQ);
    localparam logic [GNT_WIDTH-1:0] LAST_IDX  = GNT_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                state_q, state_d;
    logic [GNT_WIDTH-1:0]  gnt_q, gnt_d;
    logic [GNT_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [GNT_WIDTH-1:0]  pick;
    logic                  found;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Search order ptr_q, ptr_q+1, ... with an explicit wrap so that
    // non-power-of-2 requester counts never index past the last requester.
    always_comb begin
        logic [GNT_WIDTH:0] sum;
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (GNT_WIDTH+1)'(k);
            if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
            if (!found && req_valid[sum[GNT_WIDTH-1:0]]) begin
                found = 1'b1;
                pick  = sum[GNT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = ONE_HOT0 << pick;
                    addr_d    = addr_arr[pick];
                    gnt_d     = pick;
                    ptr_d     = (pick == LAST_IDX) ? '0 : pick + 1'b1;
                    state_d   = READ;
                end
            end
            READ: state_d = RESP;
            RESP: begin
                // addr_q is frozen, so rom_data stays stable while the response is held
                rsp_valid = ONE_HOT0 << gnt_q;
                rsp_data  = rom_data;
                if (rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
        end
    end

    assign rom_addr = addr_q;

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(rsp_valid));
    a_rsp_valid_held: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid != '0 && (rsp_valid & rsp_ready) == '0) |=> rsp_valid == $past(rsp_valid));

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: a 2-requester instance for the main scenarios
// and a 3-requester instance for the non-power-of-2 pointer wrap.
module tb_rom_read_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // two-requester instance
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2*AW-1:0] req_addr;
    logic [DW-1:0] rsp_data, rom_data;
    logic [AW-1:0] rom_addr;

    // three-requester instance
    logic [2:0]    req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [3*AW-1:0] req_addr3;
    logic [DW-1:0] rsp_data3, rom_data3;
    logic [AW-1:0] rom_addr3;

    logic [DW-1:0] rom [16];

    int checks = 0;
    int errors = 0;

    rom_read_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    rom_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_addr(req_addr3), .req_ready(req_ready3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rom_addr(rom_addr3), .rom_data(rom_data3)
    );

    // synchronous-read ROM models, one per instance
    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data3 <= rom[rom_addr3];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]    exp_g;
        logic [DW-1:0] exp_d;

        for (int i = 0; i < 16; i++) rom[i] = (i < 4) ? DW'(i) : DW'(32'hA0 + i);
        req_valid  = '0; req_addr  = '0; rsp_ready  = '0;
        req_valid3 = '0; req_addr3 = '0; rsp_ready3 = '0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data",  rsp_data, 0);
        check("rst_rom_addr",  rom_addr, 0);

        // 1: single read of address 2 from requester 0
        tick();
        req_valid = 2'b01; req_addr = {4'd0, 4'd2}; rsp_ready = 2'b11;
        @(negedge clk);
        check("t1_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_read_ready", req_ready, 2'b00);
        check("t1_read_rsp",   rsp_valid, 2'b00);
        check("t1_rom_addr",   rom_addr, 2);
        tick();
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_data",  rsp_data, 2);
        tick();
        @(negedge clk);
        check("t1_idle_valid", rsp_valid, 2'b00);
        check("t1_idle_data",  rsp_data, 0);

        // 2: both requesters continuously valid, alternating grants
        do_reset();
        req_valid = 2'b11; req_addr = {4'd3, 4'd1}; rsp_ready = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 1) ? 2'b10 : 2'b01;
            exp_d = (n % 2 == 1) ? 32'd3 : 32'd1;
            @(negedge clk);
            check("t2_grant", req_ready, exp_g);
            tick();
            @(negedge clk);
            check("t2_read_ready", req_ready, 2'b00);
            tick();
            @(negedge clk);
            check("t2_rsp_valid", rsp_valid, exp_g);
            check("t2_rsp_data",  rsp_data, exp_d);
            check("t2_rsp_ready", req_ready, 2'b00);
            tick();
        end

        // 3: backpressure for 5 cycles, requester 1 waiting meanwhile
        do_reset();
        req_valid = 2'b01; req_addr = {4'd1, 4'd3}; rsp_ready = 2'b00;
        @(negedge clk);
        check("t3_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 6; i++) begin
            rsp_ready = (i == 5) ? 2'b01 : 2'b00;
            @(negedge clk);
            check("t3_hold_valid", rsp_valid, 2'b01);
            check("t3_hold_data",  rsp_data, 3);
            check("t3_hold_ready", req_ready, 2'b00);
            tick();
        end
        rsp_ready = 2'b00;
        @(negedge clk);
        check("t3_next_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b10;
        @(negedge clk);
        check("t3_r1_valid", rsp_valid, 2'b10);
        check("t3_r1_data",  rsp_data, 1);
        tick();

        // 4: wrong rsp_ready bit is ignored
        do_reset();
        req_valid = 2'b01; req_addr = {4'd0, 4'd2}; rsp_ready = 2'b10;
        @(negedge clk);
        check("t4_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_held_valid", rsp_valid, 2'b01);
            check("t4_held_data",  rsp_data, 2);
            tick();
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        check("t4_accept_valid", rsp_valid, 2'b01);
        tick();
        @(negedge clk);
        check("t4_after_valid", rsp_valid, 2'b00);

        // 5: reset during READ drops the read and restarts the pointer
        tick();
        rsp_ready = 2'b11; req_valid = 2'b01; req_addr = {4'd3, 4'd1};
        @(negedge clk);
        check("t5_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        check("t5_rsp_valid", rsp_valid, 2'b00);
        check("t5_rsp_data",  rsp_data, 0);
        check("t5_grant_ptr", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        check("t5_rsp_after", rsp_valid, 2'b01);
        check("t5_data_after", rsp_data, 1);
        tick();

        // 6: three requesters, pointer wrap from 2 back to 0
        do_reset();
        req_valid3 = 3'b100; req_addr3 = {4'd3, 4'd2, 4'd1}; rsp_ready3 = 3'b111;
        @(negedge clk);
        check("t6_grant2", req_ready3, 3'b100);
        tick();
        req_valid3 = 3'b000;
        tick();
        @(negedge clk);
        check("t6_rsp2_valid", rsp_valid3, 3'b100);
        check("t6_rsp2_data",  rsp_data3, 3);
        tick();
        req_valid3 = 3'b111;
        @(negedge clk);
        check("t6_grant0", req_ready3, 3'b001);
        tick();
        @(negedge clk);
        check("t6_read_ready", req_ready3, 3'b000);
        tick();
        @(negedge clk);
        check("t6_rsp0_valid", rsp_valid3, 3'b001);
        check("t6_rsp0_data",  rsp_data3, 1);
        tick();
        @(negedge clk);
        check("t6_grant1", req_ready3, 3'b010);
        tick();
        req_valid3 = 3'b000;
        tick();
        @(negedge clk);
        check("t6_rsp1_valid", rsp_valid3, 3'b010);
        check("t6_rsp1_data",  rsp_data3, 2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
